// File: rtl/rgb_led_ctrl.sv
// rgb_led_ctrl
//   Colour sequencer for the three-channel RGB LED driver. Each channel gets
//   an 8-bit PWM output that feeds one RGBnPWM input. A valid/ready request
//   port takes a new target colour. The colour is applied either as a jump or
//   as a linear fade, one LSB per FADE_DIV PWM periods. The duty register
//   only changes at the end of a 256-clock period, so no PWM period ever sees
//   a partial update.
//
// Parameters
//   FADE_DIV   PWM periods per 1-LSB fade step (1..65535)
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   req_valid  colour request valid
//   req_ready  block can accept a request (high only in IDLE)
//   req_rgb    target duty {R[23:16], G[15:8], B[7:0]}
//   req_fade   1 = ramp to target, 0 = jump to target
//   busy       a request is being applied
//   cur_rgb    duties currently in effect, same packing as req_rgb
//   pwm        [0]=red, [1]=green, [2]=blue
//   led_en     driver enable (RGBLEDEN), registered
module rgb_led_ctrl #(
  parameter int unsigned FADE_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_rgb,
  input  logic        req_fade,
  output logic        busy,
  output logic [23:0] cur_rgb,
  output logic [2:0]  pwm,
  output logic        led_en
);

  localparam logic [15:0] STEP_LAST = 16'(FADE_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    FADE  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [7:0]  cnt;
  logic [15:0] step_ctr;
  logic [23:0] target;
  logic [23:0] stepped;   // cur_rgb moved one LSB toward target, per channel
  logic        boundary;  // this edge closes a PWM period
  logic        step_due;  // this boundary performs a fade step
  logic        transfer;

  assign boundary = (cnt == 8'hFF);
  assign step_due = (step_ctr == STEP_LAST);
  assign transfer = req_valid && req_ready;

  // Per-channel step logic and PWM compare. Channel gi uses bits
  // [gi*8 +: 8], so gi=2 is red, which drives pwm[0].
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      logic [7:0] cur_ch;
      logic [7:0] tgt_ch;

      assign cur_ch = cur_rgb[gi*8 +: 8];
      assign tgt_ch = target[gi*8 +: 8];

      assign stepped[gi*8 +: 8] = (cur_ch < tgt_ch) ? cur_ch + 8'd1 :
                                  (cur_ch > tgt_ch) ? cur_ch - 8'd1 :
                                  cur_ch;

      assign pwm[2-gi] = (cnt < cur_ch);
    end
  endgenerate

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (transfer) begin
          state_next = req_fade ? FADE : APPLY;
        end
      end
      APPLY: begin
        if (boundary) begin
          state_next = IDLE;
        end
      end
      FADE: begin
        // A step that lands on the target ends the fade on the same edge.
        // This also covers entering with cur_rgb already equal to target.
        if (boundary && step_due && (stepped == target)) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready = (state == IDLE);
    busy      = (state != IDLE);
  end

  // Datapath: PWM counter, request capture, duty updates, LED enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= 8'd0;
      step_ctr <= 16'd0;
      cur_rgb  <= 24'd0;
      target   <= 24'd0;
      led_en   <= 1'b0;
    end else begin
      cnt    <= cnt + 8'd1;
      led_en <= (cur_rgb != 24'd0) || (state != IDLE);
      case (state)
        IDLE: begin
          if (transfer) begin
            target   <= req_rgb;
            step_ctr <= 16'd0;
          end
        end
        APPLY: begin
          if (boundary) begin
            cur_rgb <= target;
          end
        end
        FADE: begin
          if (boundary) begin
            if (step_due) begin
              step_ctr <= 16'd0;
              cur_rgb  <= stepped;
            end else begin
              step_ctr <= step_ctr + 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_led_ctrl.sv
// Testbench for rgb_led_ctrl (FADE_DIV=2). Requests push the expected final
// colour and period count into a scoreboard. A monitor pops an entry each
// time busy falls and compares it against the DUT.
module tb_rgb_led_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [23:0] req_rgb;
  logic        req_fade;
  logic        busy;
  logic [23:0] cur_rgb;
  logic [2:0]  pwm;
  logic        led_en;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [23:0] rgb;
    int          periods;
  } exp_t;

  exp_t sb[$];

  // Reference PWM phase: starts at 0 on reset and counts every clock.
  logic [7:0] tb_cnt;

  rgb_led_ctrl #(.FADE_DIV(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rgb   (req_rgb),
    .req_fade  (req_fade),
    .busy      (busy),
    .cur_rgb   (cur_rgb),
    .pwm       (pwm),
    .led_en    (led_en)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cnt <= 8'd0;
    else        tb_cnt <= tb_cnt + 8'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: counts period boundaries while busy. On completion it checks
  // the colour, the number of periods and that completion was on a boundary.
  initial begin
    int   bnd;
    logic prev_busy;
    exp_t e;
    bnd = 0;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_busy && tb_cnt == 8'd0) bnd++;
      if (prev_busy && !busy) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_done", 32'(cur_rgb), 32'hFFFFFFFF);
        end else begin
          e = sb.pop_front();
          check("done_rgb", 32'(cur_rgb), 32'(e.rgb));
          check("done_periods", 32'(bnd), 32'(e.periods));
          check("done_at_boundary", 32'(tb_cnt), 32'd0);
          $display("done: cur_rgb=%06h periods=%0d", cur_rgb, bnd);
        end
      end
      if (!prev_busy && busy) bnd = 0;
      prev_busy = busy;
    end
  end

  task automatic send(input logic [23:0] rgb, input logic fade, input int periods);
    exp_t e;
    int   n;
    req_rgb   = rgb;
    req_fade  = fade;
    req_valid = 1'b1;
    e.rgb     = rgb;
    e.periods = periods;
    sb.push_back(e);
    n = 0;
    while (!req_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      $display("FAIL send_timeout: req_ready stuck low for rgb=%06h", rgb);
      $fatal(1, "request never accepted");
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    $display("sent: rgb=%06h fade=%0d at cnt=%0d", rgb, fade, tb_cnt);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic check_period(input logic [7:0] r, input logic [7:0] g,
                              input logic [7:0] b, input string name);
    int         errs;
    logic [2:0] ep;
    errs = 0;
    while (tb_cnt != 8'd0) @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      ep = {(tb_cnt < b), (tb_cnt < g), (tb_cnt < r)};
      if (pwm !== ep) errs++;
      @(negedge clk);
    end
    check(name, 32'(errs), 32'd0);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_pwm"},       32'(pwm),       32'd0);
    check({tag, "_cur_rgb"},   32'(cur_rgb),   32'd0);
    check({tag, "_led_en"},    32'(led_en),    32'd0);
    check({tag, "_busy"},      32'(busy),      32'd0);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_rgb   = 24'd0;
    req_fade  = 1'b0;
    #2;
    reset_checks("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Jump to 0x80FF00 issued at cnt=10; applied at the next boundary.
    while (tb_cnt != 8'd10) @(negedge clk);
    send(24'h80FF00, 1'b0, 1);
    check("t2_busy", 32'(busy), 32'd1);
    check("t2_ready_low", 32'(req_ready), 32'd0);
    wait_idle();
    check("t2_ready", 32'(req_ready), 32'd1);
    check("t2_led_en", 32'(led_en), 32'd1);
    check_period(8'h80, 8'hFF, 8'h00, "t2_pwm");

    // Asynchronous reset mid-run while the PWM is active.
    check("t1_pwm_active", 32'(pwm), 32'd3);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    reset_checks("t1");
    @(negedge clk);
    rst_n = 1'b1;

    // Fade from 0 to 0x030002: three steps, two periods each.
    send(24'h030002, 1'b1, 6);
    wait_idle();
    check("t3_led_en", 32'(led_en), 32'd1);

    // Mixed fade: red down and green up on the same boundaries.
    send(24'h020000, 1'b0, 1);
    wait_idle();
    send(24'h000200, 1'b1, 4);
    wait_idle();

    // Second request held during a fade: accepted one clock after IDLE.
    send(24'h010201, 1'b1, 2);
    check("t5_ready_low", 32'(req_ready), 32'd0);
    send(24'h010101, 1'b0, 1);
    check("t5_accept_phase", 32'(tb_cnt), 32'd1);
    wait_idle();

    // Jump to black: led_en drops one clock after returning to IDLE.
    send(24'h000000, 1'b0, 1);
    wait_idle();
    check("t6_led_en_hold", 32'(led_en), 32'd1);
    @(negedge clk);
    check("t6_led_en_fall", 32'(led_en), 32'd0);
    check_period(8'h00, 8'h00, 8'h00, "t6_pwm");

    // Fade to the current colour: finishes at the first step evaluation.
    send(24'h000000, 1'b1, 2);
    wait_idle();

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
